// File: rtl/silu_pwl_pkg.sv
// rtl/silu_pwl_pkg.sv - shared SiLU PWL segment tables and types
package silu_pwl_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int SEG_N     = 6;

    // Segment index, ordered by increasing x.
    typedef enum logic [2:0] {
        SEG_LOW      = 3'd0,
        SEG_NEG_TAIL = 3'd1,
        SEG_NEG_KNEE = 3'd2,
        SEG_POS_KNEE = 3'd3,
        SEG_POS_TAIL = 3'd4,
        SEG_HIGH     = 3'd5
    } seg_t;

    // Inclusive lower bound of each segment (entry 0 is the most negative value).
    localparam logic [SEG_N-1:0][15:0] SEG_LO =
        {16'h0600, 16'h0280, 16'h0000, 16'hFD80, 16'hFA00, 16'h8000};

    // Origin of delta within each segment.
    localparam logic [SEG_N-1:0][15:0] SEG_BASE =
        {16'h0000, 16'h0280, 16'h0000, 16'hFD80, 16'hFA00, 16'h0000};

    // Derivative value at the segment base (constant value for the flat ends).
    localparam logic [SEG_N-1:0][15:0] SEG_BIAS =
        {16'h0100, 16'h011C, 16'h0080, 16'hFFE4, 16'h0000, 16'h0000};

    // Slope is 2^-shift; the flat end segments ignore it.
    localparam logic [SEG_N-1:0][2:0] SEG_SHIFT =
        {3'd0, 3'd5, 3'd2, 3'd2, 3'd5, 3'd0};

    // 1: slope term is subtracted from the bias.
    localparam logic [SEG_N-1:0] SEG_NEG = 6'b010010;

endpackage

// File: rtl/silu_grad_seg_lut.sv
// rtl/silu_grad_seg_lut.sv - breakpoint compare and segment coefficient lookup
module silu_grad_seg_lut
    import silu_pwl_pkg::*;
(
    input  logic [15:0] x,
    output seg_t        seg,
    output logic [15:0] base,
    output logic [15:0] bias,
    output logic [2:0]  shift,
    output logic        neg
);

    // Breakpoints are monotonic, so the last bound that x reaches names its segment.
    always_comb begin
        seg = SEG_LOW;
        for (int i = 1; i < SEG_N; i++) begin
            if ($signed(x) >= $signed(SEG_LO[i])) begin
                seg = seg_t'(i);
            end
        end
    end

    assign base  = SEG_BASE[seg];
    assign bias  = SEG_BIAS[seg];
    assign shift = SEG_SHIFT[seg];
    assign neg   = SEG_NEG[seg];

endmodule

// File: rtl/silu_grad_pwl.sv
// rtl/silu_grad_pwl.sv - 3-stage SiLU derivative PWL and gradient multiply
module silu_grad_pwl #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int SAT_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] g_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] d_out,
    output logic [DATA_W-1:0] g_out,
    output logic              sat
);

    import silu_pwl_pkg::*;

    localparam logic signed [31:0] Q_MAX = 32'sd32767;
    localparam logic signed [31:0] Q_MIN = -32'sd32768;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // S0 combinational: segment selection and delta from the segment base.
    seg_t               lut_seg;
    logic [15:0]        lut_base;
    logic [15:0]        lut_bias;
    logic [2:0]         lut_shift;
    logic               lut_neg;
    logic signed [16:0] delta_s0;

    silu_grad_seg_lut u_lut (
        .x     (x_in),
        .seg   (lut_seg),
        .base  (lut_base),
        .bias  (lut_bias),
        .shift (lut_shift),
        .neg   (lut_neg)
    );

    assign delta_s0 = $signed({x_in[15], x_in}) - $signed({lut_base[15], lut_base});

    // S1 registers.
    logic               v1;
    seg_t               seg1;
    logic signed [16:0] delta1;
    logic [DATA_W-1:0]  g1;
    logic [15:0]        bias1;
    logic [2:0]         shift1;
    logic               neg1;

    // S1 combinational: derivative from bias and shifted delta.
    logic signed [16:0] slope_s1;
    logic [15:0]        term_s1;
    logic [15:0]        d_s1;
    logic               flat_s1;

    assign slope_s1 = delta1 >>> shift1;
    assign term_s1  = 16'(slope_s1);
    assign flat_s1  = (seg1 == SEG_LOW) || (seg1 == SEG_HIGH);
    assign d_s1     = flat_s1 ? bias1 : (neg1 ? bias1 - term_s1 : bias1 + term_s1);

    // S2 registers.
    logic              v2;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] g2;

    // S2 combinational: Q8.8 product, floor-scaled back to Q8.8.
    logic signed [31:0] prod_s2;
    logic signed [31:0] q_s2;
    logic [DATA_W-1:0]  g_s2;
    logic               sat_s2;

    assign prod_s2 = $signed(d2) * $signed(g2);
    assign q_s2    = prod_s2 >>> FRAC_BITS;

    if (SAT_EN != 0) begin : g_sat
        // Clip to the signed 16-bit range and flag the clip.
        always_comb begin
            g_s2   = 16'(q_s2);
            sat_s2 = 1'b0;
            if (q_s2 > Q_MAX) begin
                g_s2   = 16'h7FFF;
                sat_s2 = 1'b1;
            end else if (q_s2 < Q_MIN) begin
                g_s2   = 16'h8000;
                sat_s2 = 1'b1;
            end
        end
    end else begin : g_wrap
        assign g_s2   = 16'(q_s2);
        assign sat_s2 = 1'b0;
    end

    // Pipeline registers: all stages load together on adv, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            seg1      <= SEG_LOW;
            delta1    <= '0;
            g1        <= '0;
            bias1     <= '0;
            shift1    <= '0;
            neg1      <= 1'b0;
            v2        <= 1'b0;
            d2        <= '0;
            g2        <= '0;
            out_valid <= 1'b0;
            d_out     <= '0;
            g_out     <= '0;
            sat       <= 1'b0;
        end else if (adv) begin
            v1        <= in_valid;
            seg1      <= lut_seg;
            delta1    <= delta_s0;
            g1        <= g_in;
            bias1     <= lut_bias;
            shift1    <= lut_shift;
            neg1      <= lut_neg;
            v2        <= v1;
            d2        <= d_s1;
            g2        <= g1;
            out_valid <= v2;
            d_out     <= d2;
            g_out     <= g_s2;
            sat       <= sat_s2;
        end
    end

endmodule

// File: tb/tb_silu_grad_pwl.sv
// tb/tb_silu_grad_pwl.sv - scoreboard bench for silu_grad_pwl
module tb_silu_grad_pwl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] x_in = '0;
    logic [15:0] g_in = '0;
    logic        in_ready, out_valid, sat;
    logic [15:0] d_out, g_out;
    logic        in_ready_w, out_valid_w, sat_w;
    logic [15:0] d_out_w, g_out_w;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] g;
        logic        s;
        logic [15:0] gw;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   checks = 0;
    int   failures = 0;

    logic        stall_prev = 1'b0;
    logic [15:0] d_prev, g_prev;
    logic        s_prev;

    always #5 clk = ~clk;

    silu_grad_pwl #(.DATA_W(16), .FRAC_BITS(8), .SAT_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .g_in(g_in), .out_valid(out_valid), .out_ready(out_ready),
        .d_out(d_out), .g_out(g_out), .sat(sat)
    );

    silu_grad_pwl #(.DATA_W(16), .FRAC_BITS(8), .SAT_EN(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .x_in(x_in), .g_in(g_in), .out_valid(out_valid_w), .out_ready(out_ready),
        .d_out(d_out_w), .g_out(g_out_w), .sat(sat_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Derivative straight from the segment table, with integer x.
    function automatic logic [15:0] model_d(input logic [15:0] x);
        int xi;
        int d;
        xi = int'($signed(x));
        if (xi < -1536)      d = 0;
        else if (xi < -640)  d = -((xi + 1536) >>> 5);
        else if (xi < 0)     d = -28 + ((xi + 640) >>> 2);
        else if (xi < 640)   d = 128 + (xi >>> 2);
        else if (xi < 1536)  d = 284 - ((xi - 640) >>> 5);
        else                 d = 256;
        return d[15:0];
    endfunction

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] g);
        exp_t e;
        int   d;
        int   q;
        d = int'($signed(model_d(x)));
        q = (d * int'($signed(g))) >>> 8;
        e.d  = d[15:0];
        e.gw = q[15:0];
        e.s  = (q > 32767) || (q < -32768);
        if (q > 32767)       e.g = 16'h7FFF;
        else if (q < -32768) e.g = 16'h8000;
        else                 e.g = q[15:0];
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic drive(input logic [15:0] x, input logic [15:0] g, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        x_in = x;
        g_in = g;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [15:0] x, input logic [15:0] g,
                            input logic [15:0] ed, input logic [15:0] eg, input logic es);
        exp_t e;
        e = model(x, g);
        e.d = ed;
        e.g = eg;
        e.s = es;
        drive(x, g, e);
    endtask

    task automatic send_rand(input logic [15:0] x, input logic [15:0] g);
        drive(x, g, model(x, g));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop on transfer, hold check while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            chk("wrap_valid", {31'd0, out_valid_w}, {31'd0, out_valid});
            if (stall_prev && out_valid) begin
                chk("hold_d", {16'd0, d_out}, {16'd0, d_prev});
                chk("hold_g", {16'd0, g_out}, {16'd0, g_prev});
                chk("hold_sat", {31'd0, sat}, {31'd0, s_prev});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("d_out", {16'd0, d_out}, {16'd0, got.d});
                    chk("g_out", {16'd0, g_out}, {16'd0, got.g});
                    chk("sat", {31'd0, sat}, {31'd0, got.s});
                    chk("wrap_g_out", {16'd0, g_out_w}, {16'd0, got.gw});
                    chk("wrap_sat", {31'd0, sat_w}, 32'd0);
                end
            end
            stall_prev = out_valid && !out_ready;
            d_prev = d_out;
            g_prev = g_out;
            s_prev = sat;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_d_out", {16'd0, d_out}, 32'd0);
        chk("rst_g_out", {16'd0, g_out}, 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single sample with latency check.
        send_exp(16'h0000, 16'h0100, 16'h0080, 16'h0080, 1'b0);
        @(negedge clk);
        chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle3", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Directed table points, breakpoints and saturation.
        send_exp(16'hFC00, 16'h0100, 16'hFFF0, 16'hFFF0, 1'b0);
        send_exp(16'hFA00, 16'h0100, 16'h0000, 16'h0000, 1'b0);
        send_exp(16'h8000, 16'h0100, 16'h0000, 16'h0000, 1'b0);
        send_exp(16'h0100, 16'h7FFF, 16'h00C0, 16'h5FFF, 1'b0);
        send_exp(16'h0800, 16'h0200, 16'h0100, 16'h0200, 1'b0);
        send_exp(16'h0280, 16'h7FFF, 16'h011C, 16'h7FFF, 1'b1);
        send_exp(16'h0280, 16'h8000, 16'h011C, 16'h8000, 1'b1);
        send_exp(16'hFD80, 16'h0100, 16'hFFE4, 16'hFFE4, 1'b0);
        send_exp(16'hFFFF, 16'h0100, 16'h0083, 16'h0083, 1'b0);
        send_exp(16'h05FF, 16'h0100, 16'h0101, 16'h0101, 1'b0);
        send_exp(16'h0600, 16'h0100, 16'h0100, 16'h0100, 1'b0);
        send_exp(16'hF9FF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0);
        drain();

        // Backpressure: 8 back-to-back inputs with a 5-cycle output stall.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_rand(16'($urandom_range(16'hF800, 16'hFFFF) + 16'(i * 16'h0140)),
                              16'($urandom));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                repeat (2) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random output backpressure.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send_rand(16'($urandom), 16'($urandom));
                end
            end
            begin
                repeat (30) begin
                    @(posedge clk);
                    #2 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with samples in flight.
        send_rand(16'h0040, 16'h0300);
        send_rand(16'hFB00, 16'h0123);
        send_rand(16'h0300, 16'hF000);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_g_out", {16'd0, g_out}, 32'd0);
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        send_exp(16'h0100, 16'h0100, 16'h00C0, 16'h00C0, 1'b0);
        @(negedge clk);
        chk("post_rst_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("post_rst_cycle2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("post_rst_cycle3", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
